// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch controller.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  // Instruction progMem substitutes when flush or hold is asserted (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive instructions
  localparam logic [31:0] PC_STEP = 32'd4;

  // Mask that keeps an address word-aligned and inside the program memory
  function automatic logic [31:0] word_mask(input int unsigned mem_bytes);
    return (32'(mem_bytes) - 32'd1) & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_reg
// Brief    : Fetch PC register with next-PC mux and word-align / wrap mask.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        load_target,
  input  logic        advance,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        misaligned
);

  // Clearing bits [1:0] together with the size mask aligns and wraps in one step
  localparam logic [31:0] ADDR_MASK = word_mask(MEM_BYTES);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next-PC select: redirect target beats sequential advance; otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (load_target) begin
      pc_d = redirect_pc & ADDR_MASK;
    end else if (advance) begin
      pc_d = (pc_q + PC_STEP) & ADDR_MASK;
    end
  end

  // PC register, synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = |redirect_pc[1:0];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch sequencer for progMem: owns the PC, drives flush/hold and
//            tags the registered progMem output with valid + PC.
// Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned MEM_BYTES    = 256,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  output logic        flush,
  output logic        hold,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        misalign,
  output logic [15:0] stall_cnt
);

  // Counter only needs to hold FLUSH_CYCLES-1
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  fetch_state_t     state_q,     state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             if_valid_q,  if_valid_d;
  logic [31:0]      if_pc_q,     if_pc_d;
  logic             misalign_q,  misalign_d;

  logic             w_load_target;
  logic             w_advance;
  logic             w_misaligned;
  logic [31:0]      w_pc;

  fetch_pc_reg #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_reg (
    .Clock       (Clock),
    .nReset      (nReset),
    .load_target (w_load_target),
    .advance     (w_advance),
    .redirect_pc (redirect_pc),
    .pc          (w_pc),
    .misaligned  (w_misaligned)
  );

  // Next-state, PC control and flush/hold; redirect overrides every state
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    w_load_target = 1'b0;
    w_advance     = 1'b0;

    flush = (state_q == BOOT) | (state_q == FLUSH) | redirect;
    hold  = stall & ~flush;

    if (redirect) begin
      w_load_target = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end else begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end
    end else begin
      case (state_q)
        BOOT: begin
          // The BOOT fetch is flushed, so RESET_PC is fetched again in RUN
          state_d = RUN;
        end
        RUN: begin
          if (stall) begin
            state_d = HOLD;
          end else begin
            w_advance = 1'b1;
          end
        end
        HOLD: begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
          // On release the fetch this cycle is real, so move past it
          if (!stall) begin
            state_d   = RUN;
            w_advance = 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q <= CNT_ONE) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Downstream tag mirrors progMem's one-cycle registered latency
  always_comb begin
    if_valid_d = ~flush & ~hold;
    if_pc_d    = w_pc;
    misalign_d = redirect & w_misaligned;
  end

  // State, counters and output tags; reset discards any pending flush count
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= BOOT;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign PC        = w_pc;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign misalign  = misalign_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl
//            (RESET_PC=0, MEM_BYTES=256, FLUSH_CYCLES=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] PC;
  logic        flush;
  logic        hold;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        misalign;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(
    .RESET_PC     (32'h0),
    .MEM_BYTES    (256),
    .FLUSH_CYCLES (2)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .PC          (PC),
    .flush       (flush),
    .hold        (hold),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .misalign    (misalign),
    .stall_cnt   (stall_cnt)
  );

  always #5 Clock = ~Clock;

  // Advance one cycle, then apply this cycle's inputs and let them settle
  task automatic cyc(input logic rst_n, input logic st, input logic rd,
                     input logic [31:0] rpc);
    @(posedge Clock);
    #1;
    nReset      = rst_n;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Top-level time limit
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  initial begin
    // Reset held for two edges
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc",        PC,                32'h0);
    chk("rst_if_valid",  32'(if_valid),     32'd0);
    chk("rst_if_pc",     if_pc,             32'h0);
    chk("rst_misalign",  32'(misalign),     32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt),    32'd0);
    chk("rst_flush",     32'(flush),        32'd1);
    nReset = 1'b1;  // this cycle is the BOOT cycle
    #1;
    chk("boot_flush",    32'(flush),        32'd1);
    chk("boot_pc",       PC,                32'h0);

    // C1: RUN refetches RESET_PC
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c1_pc",         PC,                32'h0);
    chk("c1_flush",      32'(flush),        32'd0);
    chk("c1_if_valid",   32'(if_valid),     32'd0);
    // C2
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c2_pc",         PC,                32'h4);
    chk("c2_if_valid",   32'(if_valid),     32'd1);
    chk("c2_if_pc",      if_pc,             32'h0);
    // C3: PC=8, start 3-cycle stall
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c3_pc",         PC,                32'h8);
    chk("c3_if_pc",      if_pc,             32'h4);
    chk("c3_hold",       32'(hold),         32'd1);
    // C4
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c4_pc",         PC,                32'h8);
    chk("c4_if_valid",   32'(if_valid),     32'd0);
    chk("c4_stall_cnt",  32'(stall_cnt),    32'd0);
    // C5: last stall cycle
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c5_pc",         PC,                32'h8);
    chk("c5_if_valid",   32'(if_valid),     32'd0);
    chk("c5_stall_cnt",  32'(stall_cnt),    32'd1);
    // C6: stall released, fetch at 8 is real
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c6_pc",         PC,                32'h8);
    chk("c6_hold",       32'(hold),         32'd0);
    chk("c6_if_valid",   32'(if_valid),     32'd0);
    // C7
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c7_pc",         PC,                32'hC);
    chk("c7_if_valid",   32'(if_valid),     32'd1);
    chk("c7_if_pc",      if_pc,             32'h8);
    chk("c7_stall_cnt",  32'(stall_cnt),    32'd3);
    // C8: PC=0x10, redirect to 0x40
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    chk("c8_pc",         PC,                32'h10);
    chk("c8_flush",      32'(flush),        32'd1);
    chk("c8_if_pc",      if_pc,             32'hC);
    // C9: FLUSH
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c9_pc",         PC,                32'h40);
    chk("c9_flush",      32'(flush),        32'd1);
    chk("c9_if_valid",   32'(if_valid),     32'd0);
    chk("c9_misalign",   32'(misalign),     32'd0);
    // C10: back in RUN
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c10_pc",        PC,                32'h40);
    chk("c10_flush",     32'(flush),        32'd0);
    chk("c10_if_valid",  32'(if_valid),     32'd0);
    // C11: first valid after redirect is 0x40; then stall+misaligned redirect
    cyc(1'b1, 1'b1, 1'b1, 32'h43);
    chk("c11_if_valid",  32'(if_valid),     32'd1);
    chk("c11_if_pc",     if_pc,             32'h40);
    chk("c11_hold",      32'(hold),         32'd0);
    chk("c11_flush",     32'(flush),        32'd1);
    // C12
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c12_pc",        PC,                32'h40);
    chk("c12_misalign",  32'(misalign),     32'd1);
    chk("c12_stall_cnt", 32'(stall_cnt),    32'd3);
    chk("c12_if_valid",  32'(if_valid),     32'd0);
    // C13: misalign was one cycle; redirect to 0xF8 for wrap test
    cyc(1'b1, 1'b0, 1'b1, 32'hF8);
    chk("c13_misalign",  32'(misalign),     32'd0);
    chk("c13_pc",        PC,                32'h40);
    // C14..C18
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c14_pc",        PC,                32'hF8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c15_pc",        PC,                32'hF8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c16_pc",        PC,                32'hFC);
    chk("c16_if_pc",     if_pc,             32'hF8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c17_pc_wrap",   PC,                32'h0);
    chk("c17_if_pc",     if_pc,             32'hFC);
    cyc(1'b1, 1'b0, 1'b1, 32'h104);
    chk("c18_pc",        PC,                32'h4);
    chk("c18_if_pc",     if_pc,             32'h0);
    // C19: FLUSH at masked target; assert reset mid-FLUSH
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c19_pc_mask",   PC,                32'h4);
    chk("c19_misalign",  32'(misalign),     32'd0);
    // C20: BOOT after reset
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c20_pc",        PC,                32'h0);
    chk("c20_flush",     32'(flush),        32'd1);
    chk("c20_if_valid",  32'(if_valid),     32'd0);
    chk("c20_stall_cnt", 32'(stall_cnt),    32'd0);
    // C21
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c21_pc",        PC,                32'h0);
    chk("c21_flush",     32'(flush),        32'd0);
    // C22: stall to reach HOLD
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c22_pc",        PC,                32'h4);
    chk("c22_if_pc",     if_pc,             32'h0);
    // C23
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c23_pc",        PC,                32'h4);
    chk("c23_stall_cnt", 32'(stall_cnt),    32'd0);
    // C24: reset asserted mid-HOLD
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("c24_stall_cnt", 32'(stall_cnt),    32'd1);
    // C25: BOOT
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("c25_pc",        PC,                32'h0);
    chk("c25_stall_cnt", 32'(stall_cnt),    32'd0);
    chk("c25_flush",     32'(flush),        32'd1);
    chk("c25_hold",      32'(hold),         32'd0);
    // C26
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c26_pc",        PC,                32'h0);
    chk("c26_if_valid",  32'(if_valid),     32'd0);
    chk("c26_stall_cnt", 32'(stall_cnt),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
